// File: rtl/voq_scheduler.sv
// -----------------------------------------------------------------------------
// voq_scheduler
//   Per-epoch iSLIP crossbar scheduler for a 4x4 switch. At the start of every
//   epoch it snapshots the VOQ-empty matrix from the four ingress blocks. It then
//   runs N_ITER grant/accept iterations to build a conflict-free
//   ingress->egress matching. Finally it drives the per-ingress egress select
//   and a one-cycle dequeue strobe.
//
//   Epoch timeline (cyc = cycle counter value during the cycle):
//     cyc 0            SAMPLE  : request matrix registered, epoch_cnt++
//     cyc 1..2*N_ITER  GRANT / ACCEPT alternating (odd = grant, even = accept)
//     cyc 2*N_ITER+1   LOAD    : new sched_sel already visible
//     cyc 2*N_ITER+2   ISSUE   : sched_en visible for exactly this cycle
//     remaining cycles WAIT
//
// Parameters
//   EPOCH_LEN  cycles per epoch, must be >= 2*N_ITER+3
//   N_ITER     grant/accept iterations per epoch (1..4)
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   experimenting  run enable; low forces IDLE and holds the cycle counter at 0
//   is_empty[15:0] is_empty[4*i+j]=1: ingress i VOQ for egress j is empty
//   sched_sel[7:0] sched_sel[2*i+:2] = egress chosen for ingress i
//   sched_en[3:0]  one-cycle dequeue strobe per ingress
//   epoch_cnt[31:0] epochs started since reset (wraps)
//   match_cnt[31:0] total strobes issued (SCHED_STATS_EN), else tied to 0
//
// Build option
//   SCHED_STATS_EN : when defined, match_cnt accumulates popcount(sched_en)
//                    on every ISSUE cycle. When undefined, match_cnt is 0.
// -----------------------------------------------------------------------------
module voq_scheduler #(
  parameter int EPOCH_LEN = 16,
  parameter int N_ITER    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        experimenting,
  input  logic [15:0] is_empty,
  output logic [7:0]  sched_sel,
  output logic [3:0]  sched_en,
  output logic [31:0] epoch_cnt,
  output logic [31:0] match_cnt
);

  localparam int CW = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;

  localparam logic [CW-1:0] CYC_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CYC_LAST  = CW'(EPOCH_LEN - 1);
  localparam logic [CW-1:0] CYC_ACC1  = CW'(2);
  localparam logic [CW-1:0] CYC_ACCN  = CW'(2 * N_ITER);
  localparam logic [CW-1:0] CYC_LOAD  = CW'(2 * N_ITER + 1);
  localparam logic [CW-1:0] CYC_ISSUE = CW'(2 * N_ITER + 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_GRANT  = 3'd2;
  localparam logic [2:0] ST_ACCEPT = 3'd3;
  localparam logic [2:0] ST_LOAD   = 3'd4;
  localparam logic [2:0] ST_ISSUE  = 3'd5;
  localparam logic [2:0] ST_WAIT   = 3'd6;

  // First set bit of vec at or after position ptr (wrapping modulo 4), one-hot.
  function automatic logic [3:0] rr_pick(input logic [3:0] vec, input logic [1:0] ptr);
    logic [3:0] pick;
    logic       found;
    logic [1:0] idx;
    pick  = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && vec[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Index of the set bit in a one-hot (or zero) 4-bit vector.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Phase that the FSM occupies while the cycle counter holds c.
  function automatic logic [2:0] phase_of(input logic [CW-1:0] c);
    logic [2:0] ph;
    if (c == CYC_ZERO) begin
      ph = ST_SAMPLE;
    end else if (c <= CYC_ACCN) begin
      ph = c[0] ? ST_GRANT : ST_ACCEPT;
    end else if (c == CYC_LOAD) begin
      ph = ST_LOAD;
    end else if (c == CYC_ISSUE) begin
      ph = ST_ISSUE;
    end else begin
      ph = ST_WAIT;
    end
    return ph;
  endfunction

  // State
  logic [CW-1:0] cyc_q,   cyc_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   req_q,   req_d;     // req[4*i+j]: ingress i wants egress j
  logic [15:0]   grant_q, grant_d;   // grant[4*i+j]: egress j granted ingress i
  logic [3:0]    in_m_q,  in_m_d;    // ingress already matched this epoch
  logic [3:0]    out_m_q, out_m_d;   // egress already matched this epoch
  logic [7:0]    egr_q,   egr_d;     // egress matched to each ingress
  logic [7:0]    gptr_q,  gptr_d;    // grant pointer per egress
  logic [7:0]    aptr_q,  aptr_d;    // accept pointer per ingress
  logic [7:0]    sel_q,   sel_d;
  logic [3:0]    en_q,    en_d;
  logic [31:0]   epoch_q, epoch_d;

  // Combinational iteration results
  logic [15:0] grant_s;
  logic [15:0] accept_s;
  logic [3:0]  acc_in_s;    // ingress i accepted someone this iteration
  logic [3:0]  acc_out_s;   // egress j was accepted this iteration
  logic [7:0]  acc_egr_s;   // egress accepted by ingress i
  logic [7:0]  acc_ing_s;   // ingress that accepted egress j

  // Round-robin grant per free egress and accept per free ingress.
  always_comb begin
    logic [3:0] cand;
    logic [3:0] pick;
    logic [3:0] col;
    cand      = 4'b0000;
    pick      = 4'b0000;
    col       = 4'b0000;
    grant_s   = 16'h0000;
    accept_s  = 16'h0000;
    acc_in_s  = 4'b0000;
    acc_out_s = 4'b0000;
    acc_egr_s = 8'h00;
    acc_ing_s = 8'h00;

    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        cand[i] = req_q[4*i+j] & ~in_m_q[i] & ~out_m_q[j];
      end
      pick = rr_pick(cand, gptr_q[2*j+:2]);
      for (int i = 0; i < 4; i++) begin
        grant_s[4*i+j] = pick[i];
      end
    end

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        cand[j] = grant_q[4*i+j] & ~in_m_q[i];
      end
      pick = rr_pick(cand, aptr_q[2*i+:2]);
      for (int j = 0; j < 4; j++) begin
        accept_s[4*i+j] = pick[j];
      end
      acc_in_s[i]        = |pick;
      acc_egr_s[2*i+:2]  = onehot_idx(pick);
    end

    // An egress grants at most one ingress, so each column is at most one-hot.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        col[i] = accept_s[4*i+j];
      end
      acc_out_s[j]       = |col;
      acc_ing_s[2*j+:2]  = onehot_idx(col);
    end
  end

  // Next-state logic for the epoch FSM, matching state and outputs.
  always_comb begin
    cyc_d   = cyc_q;
    state_d = state_q;
    req_d   = req_q;
    grant_d = grant_q;
    in_m_d  = in_m_q;
    out_m_d = out_m_q;
    egr_d   = egr_q;
    gptr_d  = gptr_q;
    aptr_d  = aptr_q;
    sel_d   = sel_q;
    en_d    = 4'b0000;
    epoch_d = epoch_q;

    if (!experimenting) begin
      // Drop any in-flight matching; pointers, sel and counters survive.
      cyc_d   = CYC_ZERO;
      state_d = ST_IDLE;
      grant_d = 16'h0000;
      in_m_d  = 4'b0000;
      out_m_d = 4'b0000;
    end else begin
      cyc_d   = (cyc_q == CYC_LAST) ? CYC_ZERO : cyc_q + CW'(1);
      state_d = phase_of(cyc_d);
      case (state_q)
        // IDLE with experimenting high is the first cycle after a rise.
        ST_IDLE, ST_SAMPLE: begin
          req_d   = ~is_empty;
          grant_d = 16'h0000;
          in_m_d  = 4'b0000;
          out_m_d = 4'b0000;
          epoch_d = epoch_q + 32'd1;
        end
        ST_GRANT: begin
          grant_d = grant_s;
        end
        ST_ACCEPT: begin
          in_m_d  = in_m_q | acc_in_s;
          out_m_d = out_m_q | acc_out_s;
          for (int i = 0; i < 4; i++) begin
            egr_d[2*i+:2] = acc_in_s[i] ? acc_egr_s[2*i+:2] : egr_q[2*i+:2];
          end
          // Pointers only move on first-iteration accepts.
          if (cyc_q == CYC_ACC1) begin
            for (int i = 0; i < 4; i++) begin
              aptr_d[2*i+:2] = acc_in_s[i] ? acc_egr_s[2*i+:2] + 2'd1 : aptr_q[2*i+:2];
            end
            for (int j = 0; j < 4; j++) begin
              gptr_d[2*j+:2] = acc_out_s[j] ? acc_ing_s[2*j+:2] + 2'd1 : gptr_q[2*j+:2];
            end
          end else begin
            aptr_d = aptr_q;
            gptr_d = gptr_q;
          end
          // Load sel on the last accept edge so it is stable through LOAD.
          if (cyc_q == CYC_ACCN) begin
            for (int i = 0; i < 4; i++) begin
              sel_d[2*i+:2] = in_m_d[i] ? egr_d[2*i+:2] : sel_q[2*i+:2];
            end
          end else begin
            sel_d = sel_q;
          end
        end
        // Strobe registered here so that it is visible during ISSUE.
        ST_LOAD: begin
          en_d = in_m_q;
        end
        ST_ISSUE, ST_WAIT: begin
          en_d = 4'b0000;
        end
        default: begin
          state_d = ST_IDLE;
          cyc_d   = CYC_ZERO;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= CYC_ZERO;
      state_q <= ST_IDLE;
      req_q   <= 16'h0000;
      grant_q <= 16'h0000;
      in_m_q  <= 4'b0000;
      out_m_q <= 4'b0000;
      egr_q   <= 8'h00;
      gptr_q  <= 8'h00;
      aptr_q  <= 8'h00;
      sel_q   <= 8'h00;
      en_q    <= 4'b0000;
      epoch_q <= 32'h0000_0000;
    end else begin
      cyc_q   <= cyc_d;
      state_q <= state_d;
      req_q   <= req_d;
      grant_q <= grant_d;
      in_m_q  <= in_m_d;
      out_m_q <= out_m_d;
      egr_q   <= egr_d;
      gptr_q  <= gptr_d;
      aptr_q  <= aptr_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      epoch_q <= epoch_d;
    end
  end

  assign sched_sel = sel_q;
  assign sched_en  = en_q;
  assign epoch_cnt = epoch_q;

`ifdef SCHED_STATS_EN
  logic [31:0] match_q;

  // Number of set bits in a 4-bit vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Accumulate strobes actually presented to the ingress blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 32'h0000_0000;
    end else if (state_q == ST_ISSUE) begin
      match_q <= match_q + {29'h0, popcount4(en_q)};
    end else begin
      match_q <= match_q;
    end
  end

  assign match_cnt = match_q;
`else
  assign match_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_voq_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voq_scheduler
//   Self-checking bench for voq_scheduler (default parameters). A behavioural
//   iSLIP model works on integer arrays. It predicts each epoch's strobe and
//   select, the pointer evolution, and the epoch/match counters. Directed
//   epochs reproduce the documented scenarios. Randomised epochs follow,
//   mixed with mid-epoch run-enable drops and resets.
// -----------------------------------------------------------------------------
module tb_voq_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        experimenting;
  logic [15:0] is_empty;
  logic [7:0]  sched_sel;
  logic [3:0]  sched_en;
  logic [31:0] epoch_cnt;
  logic [31:0] match_cnt;

  always #5 clk = ~clk;

  voq_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .experimenting (experimenting),
    .is_empty      (is_empty),
    .sched_sel     (sched_sel),
    .sched_en      (sched_en),
    .epoch_cnt     (epoch_cnt),
    .match_cnt     (match_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         gptr[4];
  int         aptr[4];
  int         new_g[4];
  int         new_a[4];
  logic [7:0] m_sel;
  int         m_epochs;
  int         m_matches;
  logic [3:0] exp_en;
  logic [7:0] exp_sel;
  logic [3:0] seen_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_match();
`ifdef SCHED_STATS_EN
    return 32'(m_matches);
`else
    return 32'h0;
`endif
  endfunction

  // iSLIP over one epoch: compute strobe, select and post-epoch pointers.
  task automatic model_epoch(input logic [15:0] ie);
    int in_m[4];
    int out_m[4];
    int grant[4];
    int i;
    int j;
    for (int k = 0; k < 4; k++) begin
      in_m[k]  = -1;
      out_m[k] = -1;
      new_g[k] = gptr[k];
      new_a[k] = aptr[k];
    end
    for (int it = 0; it < 4; it++) begin
      for (int e = 0; e < 4; e++) begin
        grant[e] = -1;
        if (out_m[e] < 0) begin
          for (int k = 0; k < 4; k++) begin
            i = (gptr[e] + k) % 4;
            if (grant[e] < 0 && in_m[i] < 0 && !ie[4*i+e]) grant[e] = i;
          end
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (in_m[n] < 0) begin
          for (int k = 0; k < 4; k++) begin
            j = (aptr[n] + k) % 4;
            if (in_m[n] < 0 && grant[j] == n) begin
              in_m[n]  = j;
              out_m[j] = n;
              if (it == 0) begin
                new_a[n] = (j + 1) % 4;
                new_g[j] = (n + 1) % 4;
              end
            end
          end
        end
      end
    end
    exp_sel = m_sel;
    exp_en  = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if (in_m[n] >= 0) begin
        exp_sel[2*n +: 2] = 2'(in_m[n]);
        exp_en[n]         = 1'b1;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    for (int k = 0; k < 4; k++) begin
      gptr[k] = 0;
      aptr[k] = 0;
    end
    m_sel     = 8'h00;
    m_epochs  = 0;
    m_matches = 0;
    check_eq("rst_sel",   32'(sched_sel), 32'h0);
    check_eq("rst_en",    32'(sched_en),  32'h0);
    check_eq("rst_epoch", epoch_cnt,      32'h0);
    check_eq("rst_match", match_cnt,      32'h0);
    reset = 1'b0;
  endtask

  // Checks one epoch cycle c against the model's prediction.
  task automatic check_cycle(input int c);
    check_eq($sformatf("en_c%0d", c), 32'(sched_en), (c == 10) ? 32'(exp_en) : 32'h0);
    check_eq($sformatf("sel_c%0d", c), 32'(sched_sel), (c >= 9) ? 32'(exp_sel) : 32'(m_sel));
    if (c == 0) check_eq("epoch_pre", epoch_cnt, 32'(m_epochs));
    if (c == 1) check_eq("epoch_post", epoch_cnt, 32'(m_epochs + 1));
    if (c == 10) seen_en = sched_en;
  endtask

  // Full epoch; caller guarantees the DUT is at cyc 0 (or IDLE).
  task automatic do_epoch(input logic [15:0] ie);
    model_epoch(ie);
    is_empty      = ie;
    experimenting = 1'b1;
    seen_en       = 4'hx;
    for (int c = 0; c < 16; c++) begin
      check_cycle(c);
      if (c == 1) is_empty = 16'($urandom);
      tick();
    end
    gptr      = new_g;
    aptr      = new_a;
    m_sel     = exp_sel;
    m_epochs  = m_epochs + 1;
    m_matches = m_matches + $countones(exp_en);
    check_eq("match_cnt", match_cnt, exp_match());
  endtask

  // Epoch cut short at cycle stop_at by a run-enable drop or by reset.
  task automatic cut_epoch(input logic [15:0] ie, input int stop_at,
                           input bit use_reset, input int off_len);
    model_epoch(ie);
    is_empty      = ie;
    experimenting = 1'b1;
    for (int c = 0; c < stop_at; c++) begin
      check_cycle(c);
      tick();
    end
    m_epochs = m_epochs + 1;
    if (use_reset) begin
      apply_reset(3);
    end else begin
      experimenting = 1'b0;
      if (stop_at >= 3) begin
        gptr = new_g;
        aptr = new_a;
      end
      for (int k = 0; k < off_len; k++) begin
        tick();
        check_eq("off_en",    32'(sched_en),  32'h0);
        check_eq("off_sel",   32'(sched_sel), 32'(m_sel));
        check_eq("off_epoch", epoch_cnt,      32'(m_epochs));
      end
    end
  endtask

  function automatic logic [15:0] rand_empty();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom);
      default: return 16'($urandom | $urandom | $urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] old_sel;
    int         r;
    experimenting = 1'b0;
    is_empty      = 16'hFFFF;

    // Reset for 3 cycles, then 16 idle cycles with no strobe.
    apply_reset(3);
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq("idle_en",    32'(sched_en), 32'h0);
      check_eq("idle_epoch", epoch_cnt,     32'h0);
    end

    // Full request matrix for three epochs.
    do_epoch(16'h0000);
    check_eq("full1_en",  32'(seen_en),   32'hF);
    check_eq("full1_sel", 32'(sched_sel), 32'hE4);
    do_epoch(16'h0000);
    check_eq("full2_en",  32'(seen_en),   32'hF);
    check_eq("full2_sel", 32'(sched_sel), 32'hE1);
    do_epoch(16'h0000);
    check_eq("full3_epoch", epoch_cnt, 32'd3);
`ifdef SCHED_STATS_EN
    check_eq("full3_match", match_cnt, 32'd12);
`else
    check_eq("full3_match", match_cnt, 32'd0);
`endif

    // Single request ingress 2 -> egress 1.
    old_sel = sched_sel;
    do_epoch(16'hFDFF);
    check_eq("single_en",   32'(seen_en),        32'h4);
    check_eq("single_sel2", 32'(sched_sel[5:4]), 32'd1);
    check_eq("single_keep", {24'h0, sched_sel & 8'hCF}, {24'h0, old_sel & 8'hCF});

    // Ingress 0 and 3 contend for egress 2 from fresh pointers.
    apply_reset(2);
    for (int e = 0; e < 4; e++) begin
      do_epoch(16'hBFFB);
      check_eq($sformatf("contend_en%0d", e), 32'(seen_en), (e % 2 == 0) ? 32'h1 : 32'h8);
    end

    // Run enable dropped at cyc 5 for 7 cycles, then a normal epoch.
    cut_epoch(16'h0000, 5, 1'b0, 7);
    do_epoch(16'h0000);

    // Randomised traffic with occasional drops and resets.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cut_epoch(rand_empty(), $urandom_range(1, 8), 1'b0, $urandom_range(1, 8));
      end else if (r == 1) begin
        cut_epoch(rand_empty(), $urandom_range(1, 15), 1'b1, 0);
      end else begin
        do_epoch(rand_empty());
      end
    end
    check_eq("final_epoch", epoch_cnt, 32'(m_epochs));
    check_eq("final_match", match_cnt, exp_match());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
